// File: rtl/tof_pkg.sv
// Shared constants and FSM state encoding for the time-of-flight counter.
// Default word is 32 bits with 15 fraction bits, so counts go out as integer.0.
package tof_pkg;

  localparam int TOF_SIZE = 32;
  localparam int TOF_Q    = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_REF,
    ST_WAIT_REF,
    ST_GAP,
    ST_TX_MEAS,
    ST_WAIT_MEAS,
    ST_DONE
  } tof_state_e;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer plus rising-edge detect for the async echo detector.
// rise is high for one cycle, two clocks after echo is first sampled high; no backpressure.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  // [0],[1] form the synchronizer; [2] remembers the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_async};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tof_counter.sv
// Reference + measurement ultrasonic shot sequencer with echo time-of-flight capture.
// One meas_req yields one strt pulse (or one tmo); requests while busy are dropped.
module tof_counter
  import tof_pkg::*;
#(
  parameter int SIZE    = TOF_SIZE,
  parameter int Q       = TOF_Q,
  parameter int TX_LEN  = 8,
  parameter int BLANK   = 16,
  parameter int GAP_LEN = 64,
  parameter int MAX_CNT = (1 << (SIZE - 1 - Q)) - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            meas_req,
  input  logic            echo_in,
  output logic            tx_pulse,
  output logic            path_sel,
  output logic [SIZE-1:0] N_ref,
  output logic [SIZE-1:0] N_echo,
  output logic            strt,
  output logic            busy,
  output logic            tmo
);

  if (TX_LEN < 1) begin : g_bad_tx_len
    $fatal(1, "tof_counter: TX_LEN must be at least 1");
  end
  if (BLANK < 1) begin : g_bad_blank
    $fatal(1, "tof_counter: BLANK must be at least 1");
  end
  if (GAP_LEN < 1) begin : g_bad_gap
    $fatal(1, "tof_counter: GAP_LEN must be at least 1");
  end

  localparam logic [SIZE-1:0] TX_LAST  = SIZE'(TX_LEN - 1);
  localparam logic [SIZE-1:0] GAP_LAST = SIZE'(GAP_LEN - 1);
  localparam logic [SIZE-1:0] BLANK_C  = SIZE'(BLANK);
  localparam logic [SIZE-1:0] CNT_MAX  = SIZE'(MAX_CNT);

  tof_state_e      state;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] ref_hold;
  logic            rise;
  logic            echo_ok;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (echo_in),
    .rise    (rise)
  );

  // Only meaningful in the WAIT states; elsewhere the FSM never looks at it.
  assign echo_ok = rise && (cnt >= BLANK_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ref_hold <= '0;
      N_ref    <= '0;
      N_echo   <= '0;
      tx_pulse <= 1'b0;
      path_sel <= 1'b0;
      strt     <= 1'b0;
      busy     <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      strt <= 1'b0;
      tmo  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (meas_req) begin
            state    <= ST_TX_REF;
            cnt      <= '0;
            tx_pulse <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_TX_REF, ST_TX_MEAS: begin
          cnt <= cnt + SIZE'(1);
          if (cnt == TX_LAST) begin
            state    <= (state == ST_TX_REF) ? ST_WAIT_REF : ST_WAIT_MEAS;
            tx_pulse <= 1'b0;
          end
        end
        ST_WAIT_REF, ST_WAIT_MEAS: begin
          // A capture wins over the timeout when both land on CNT_MAX.
          if (echo_ok) begin
            if (state == ST_WAIT_REF) begin
              ref_hold <= cnt;
              cnt      <= '0;
              state    <= ST_GAP;
            end else begin
              N_ref  <= ref_hold << Q;
              N_echo <= cnt << Q;
              strt   <= 1'b1;
              state  <= ST_DONE;
            end
          end else if (cnt == CNT_MAX) begin
            tmo      <= 1'b1;
            busy     <= 1'b0;
            path_sel <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + SIZE'(1);
          end
        end
        ST_GAP: begin
          // cnt doubles as the dead-time counter; it is cleared again for the next burst.
          if (cnt == GAP_LAST) begin
            state    <= ST_TX_MEAS;
            cnt      <= '0;
            tx_pulse <= 1'b1;
            path_sel <= 1'b1;
          end else begin
            cnt <= cnt + SIZE'(1);
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          path_sel <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          tx_pulse <= 1'b0;
          path_sel <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tof_counter.sv
// Self-checking bench for tof_counter: per-cycle output checks against an event-timeline model.
// A short MAX_CNT keeps the timeout and edge-at-limit shots brief.
module tb_tof_counter;

  localparam int SIZE    = 32;
  localparam int Q       = 15;
  localparam int TX_LEN  = 8;
  localparam int BLANK   = 16;
  localparam int GAP_LEN = 64;
  localparam int MAX_CNT = 1200;
  localparam int THR     = (BLANK > TX_LEN) ? BLANK : TX_LEN;

  logic            clk;
  logic            rst;
  logic            meas_req;
  logic            echo_in;
  logic            tx_pulse;
  logic            path_sel;
  logic [SIZE-1:0] N_ref;
  logic [SIZE-1:0] N_echo;
  logic            strt;
  logic            busy;
  logic            tmo;

  int              vectors;
  int              miscompares;
  int              strt_seen;
  int              strt_exp;
  logic [SIZE-1:0] exp_nref;
  logic [SIZE-1:0] exp_necho;

  tof_counter #(
    .SIZE    (SIZE),
    .Q       (Q),
    .TX_LEN  (TX_LEN),
    .BLANK   (BLANK),
    .GAP_LEN (GAP_LEN),
    .MAX_CNT (MAX_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .meas_req (meas_req),
    .echo_in  (echo_in),
    .tx_pulse (tx_pulse),
    .path_sel (path_sel),
    .N_ref    (N_ref),
    .N_echo   (N_echo),
    .strt     (strt),
    .busy     (busy),
    .tmo      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic e_tx, input logic e_ps,
                           input logic e_bz, input logic e_st, input logic e_tm);
    chk({tag, " tx_pulse"}, {31'b0, tx_pulse}, {31'b0, e_tx});
    chk({tag, " path_sel"}, {31'b0, path_sel}, {31'b0, e_ps});
    chk({tag, " busy"},     {31'b0, busy},     {31'b0, e_bz});
    chk({tag, " strt"},     {31'b0, strt},     {31'b0, e_st});
    chk({tag, " tmo"},      {31'b0, tmo},      {31'b0, e_tm});
    chk({tag, " N_ref"},    N_ref,  exp_nref);
    chk({tag, " N_echo"},   N_echo, exp_necho);
    if (strt === 1'b1) strt_seen++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all($sformatf("%s idle%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Earliest echo rise (in burst-relative cycles, after synchronizer delay) that lands
  // inside the WAIT window past blanking; -1 means the shot times out.
  function automatic int first_valid(input int pre_on, input int v);
    int best;
    best = -1;
    if (pre_on >= 0 && pre_on + 2 >= THR && pre_on + 2 <= MAX_CNT) best = pre_on + 2;
    if (v >= THR && v <= MAX_CNT && (best < 0 || v < best)) best = v;
    return best;
  endfunction

  // ref_v/meas_v: cycle (relative to each burst start) at which the synchronized echo
  // rises; the pin is driven two cycles earlier. pre_on..pre_off is an extra echo pulse
  // (drive cycles) applied in both shots. req_t: cycle of a meas_req while busy
  // (-2 = the DONE cycle). abort_t: cycle after which rst is pulsed.
  task automatic run_pair(input string name, input int ref_v, input int meas_v,
                          input int pre_on, input int pre_off, input int req_t,
                          input int abort_t);
    int   cr, cm, m0, end_t, u, v, rq;
    bit   in_meas;
    logic e_tx, e_ps, e_bz, e_st, e_tm;
    string tag;
    cr = first_valid(pre_on, ref_v);
    cm = first_valid(pre_on, meas_v);
    m0 = cr + 1 + GAP_LEN;
    if (cr < 0)      end_t = MAX_CNT + 1;
    else if (cm < 0) end_t = m0 + MAX_CNT + 1;
    else             end_t = m0 + cm + 2;
    rq = (req_t == -2) ? end_t - 1 : req_t;

    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    for (int t = 0; t <= end_t; t++) begin
      in_meas = (cr >= 0) && (t >= m0);
      u    = in_meas ? t - m0 : t;
      e_tx = 1'b0;
      e_ps = in_meas;
      e_bz = 1'b1;
      e_st = 1'b0;
      e_tm = 1'b0;
      if (t == end_t) begin
        e_ps = 1'b0;
        e_bz = 1'b0;
        e_tm = (cr < 0) || (cm < 0);
      end else begin
        e_tx = (u < TX_LEN);
        if (in_meas && cm >= 0 && u == cm + 1) begin
          e_st      = 1'b1;
          exp_nref  = SIZE'(cr) << Q;
          exp_necho = SIZE'(cm) << Q;
          strt_exp++;
        end
      end
      tag = $sformatf("%s t=%0d", name, t);
      check_all(tag, e_tx, e_ps, e_bz, e_st, e_tm);

      if (t == abort_t) begin
        rst      = 1'b0;
        echo_in  = 1'b0;
        meas_req = 1'b0;
        tick();
        rst       = 1'b1;
        exp_nref  = '0;
        exp_necho = '0;
        check_all({name, " reset"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle({name, " post_reset"}, 4);
        return;
      end

      v = in_meas ? meas_v : ref_v;
      echo_in  = (pre_on >= 0 && u >= pre_on && u <= pre_off) ||
                 (v >= 0 && u >= v - 2 && u <= v + 1);
      meas_req = (t == rq);
      if (t < end_t) tick();
    end
    echo_in  = 1'b0;
    meas_req = 1'b0;
    idle(name, 3);
  endtask

  initial begin
    int rv, mv, po, pf, rt;
    vectors     = 0;
    miscompares = 0;
    strt_seen   = 0;
    strt_exp    = 0;
    exp_nref    = '0;
    exp_necho   = '0;
    rst      = 1'b0;
    meas_req = 1'b0;
    echo_in  = 1'b0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle("after_reset", 3);

    run_pair("basic",      100, 180, -1, -1, -1, -1);
    run_pair("blank_spur",  50,  50,  3,  5, -1, -1);
    run_pair("held_level",  60,  40,  1, 30, -1, -1);
    run_pair("meas_tmo",   120,  -1, -1, -1, -1, -1);
    run_pair("ref_tmo",     -1,  -1, -1, -1, -1, -1);
    run_pair("edge_at_max", MAX_CNT, MAX_CNT, -1, -1, -1, -1);
    run_pair("req_busy",    90,  70, -1, -1, 40, -1);
    run_pair("req_done",    33,  44, -1, -1, -2, -1);
    run_pair("rst_in_gap",  80, 100, -1, -1, -1, 80 + 1 + 10);
    run_pair("clean",       70, 130, -1, -1, -1, -1);

    for (int i = 0; i < 8; i++) begin
      rv = $urandom_range(500, THR);
      mv = $urandom_range(500, THR);
      po = $urandom_range(6, 0);
      pf = po + $urandom_range(3, 0);
      rt = $urandom_range(50, 0);
      run_pair($sformatf("rand%0d", i), rv, mv, po, pf, rt, -1);
    end

    chk("strt_count", SIZE'(strt_seen), SIZE'(strt_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
